// File: rtl/mchan_arb_pkg.sv
// Shared types and default sizing for the mchan transaction-queue credit arbiter.
package mchan_arb_pkg;

  localparam int NB_CTRLS_DEF        = 2;
  localparam int DATA_WIDTH_DEF      = 32;
  localparam int TRANS_CID_WIDTH_DEF = 1;
  localparam int MAX_OUTSTD_DEF      = 4;
  localparam int CNT_WIDTH_DEF       = $clog2(MAX_OUTSTD_DEF + 1);

  // Round-robin pointer is a controller index.
  localparam int RR_PTR_W = TRANS_CID_WIDTH_DEF;

  typedef logic [TRANS_CID_WIDTH_DEF-1:0] cid_t;
  typedef logic [CNT_WIDTH_DEF-1:0]       cnt_t;

endpackage

// File: rtl/trans_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after the
// pointer, searching modulo NB_CTRLS.
module trans_rr_picker
  import mchan_arb_pkg::*;
#(
  parameter int NB_CTRLS = NB_CTRLS_DEF,
  parameter int IDX_W    = $clog2(NB_CTRLS)
) (
  input  logic [NB_CTRLS-1:0] i_elig,
  input  logic [IDX_W-1:0]    i_ptr,
  output logic [NB_CTRLS-1:0] o_gnt,
  output logic [IDX_W-1:0]    o_win,
  output logic                o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    o_gnt   = '0;
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = NB_CTRLS - 1; i >= 0; i--) begin
      w_idx   = IDX_W'((int'(i_ptr) + i) % NB_CTRLS);
      o_win   = i_elig[w_idx] ? w_idx : o_win;
      o_valid = o_valid | i_elig[w_idx];
    end
    o_gnt[o_win] = o_valid;
  end

endmodule

// File: rtl/trans_credit_arbiter.sv
// Round-robin arbiter with per-controller in-flight credits, feeding a single
// transaction queue through a one-entry registered req/gnt output stage.
module trans_credit_arbiter
  import mchan_arb_pkg::*;
#(
  parameter int NB_CTRLS        = NB_CTRLS_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int TRANS_CID_WIDTH = TRANS_CID_WIDTH_DEF,
  parameter int MAX_OUTSTD      = MAX_OUTSTD_DEF,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTD + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NB_CTRLS-1:0]                  req_i,
  output logic [NB_CTRLS-1:0]                  gnt_o,
  input  logic [NB_CTRLS-1:0][DATA_WIDTH-1:0]  data_i,
  output logic                                 req_o,
  input  logic                                 gnt_i,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic [TRANS_CID_WIDTH-1:0]           cid_o,
  input  logic                                 done_i,
  input  logic [TRANS_CID_WIDTH-1:0]           done_cid_i,
  output logic [NB_CTRLS-1:0][CNT_WIDTH-1:0]   outstd_o,
  output logic                                 err_o,
  output logic                                 busy_o
);

  logic [NB_CTRLS-1:0]                w_elig;
  logic [NB_CTRLS-1:0]                w_pick_gnt;
  logic [NB_CTRLS-1:0]                w_inc;
  logic [NB_CTRLS-1:0]                w_dec;
  logic [NB_CTRLS-1:0]                w_uflow;
  logic [TRANS_CID_WIDTH-1:0]         w_win;
  logic [TRANS_CID_WIDTH-1:0]         w_ptr_nxt;
  logic                               w_valid;
  logic                               w_free;
  logic                               w_grant;
  logic                               w_cid_bad;

  logic                               r_req;
  logic [DATA_WIDTH-1:0]              r_data;
  logic [TRANS_CID_WIDTH-1:0]         r_cid;
  logic [TRANS_CID_WIDTH-1:0]         r_ptr;
  logic [NB_CTRLS-1:0][CNT_WIDTH-1:0] r_cnt;
  logic                               r_err;

  // Eligibility from registered counts only; same-cycle completions do not help.
  always_comb begin
    w_elig = '0;
    for (int k = 0; k < NB_CTRLS; k++) begin
      w_elig[k] = req_i[k] && (r_cnt[k] < CNT_WIDTH'(MAX_OUTSTD));
    end
  end

  trans_rr_picker #(
    .NB_CTRLS (NB_CTRLS),
    .IDX_W    (TRANS_CID_WIDTH)
  ) u_picker (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  assign w_free  = !r_req || gnt_i;
  assign gnt_o   = (w_free && w_valid && !rst_i) ? w_pick_gnt : '0;
  assign w_grant = |gnt_o;
  assign w_inc   = gnt_o;

  // Pointer advances to the index just past the winner, wrapping at NB_CTRLS.
  always_comb begin
    if (w_win == TRANS_CID_WIDTH'(NB_CTRLS - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + TRANS_CID_WIDTH'(1);
    end
  end

  // Decode completions into per-controller decrements and underflow attempts.
  always_comb begin
    w_dec   = '0;
    w_uflow = '0;
    for (int k = 0; k < NB_CTRLS; k++) begin
      w_dec[k]   = done_i && (done_cid_i == TRANS_CID_WIDTH'(k));
      w_uflow[k] = w_dec[k] && !w_inc[k] && (r_cnt[k] == '0);
    end
  end

  assign w_cid_bad = done_i &&
                     ({1'b0, done_cid_i} >= (TRANS_CID_WIDTH + 1)'(NB_CTRLS));

  // One-entry output stage; loads on grant, drains when the slot frees up idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req  <= 1'b0;
      r_data <= '0;
      r_cid  <= '0;
      r_ptr  <= '0;
    end else if (w_grant) begin
      r_req  <= 1'b1;
      r_data <= data_i[w_win];
      r_cid  <= w_win;
      r_ptr  <= w_ptr_nxt;
    end else if (w_free) begin
      r_req  <= 1'b0;
    end else begin
      r_req  <= r_req;
    end
  end

  // Credit counters: grant takes a credit, completion returns one, both cancel.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB_CTRLS; k++) begin
      if (rst_i) begin
        r_cnt[k] <= '0;
      end else begin
        case ({w_inc[k], w_dec[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
          2'b01:   r_cnt[k] <= (r_cnt[k] == '0) ? r_cnt[k] : r_cnt[k] - CNT_WIDTH'(1);
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  // Error pulse one cycle after an underflow attempt or an out-of-range cid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (|w_uflow) || w_cid_bad;
    end
  end

  assign req_o    = r_req;
  assign data_o   = r_data;
  assign cid_o    = r_cid;
  assign outstd_o = r_cnt;
  assign err_o    = r_err;
  assign busy_o   = r_req || (|r_cnt);

endmodule

// File: tb/tb_trans_credit_arbiter.sv
// Directed bench for trans_credit_arbiter: a vector table for the fairness and
// credit-return sequence, plus hand-written multi-cycle corner cases.
module tb_trans_credit_arbiter;

  localparam int NB  = 2;
  localparam int DW  = 32;
  localparam int CW  = 1;
  localparam int MO  = 4;
  localparam int CNW = 3;

  localparam logic [DW-1:0] D0 = 32'h0000_00A0;
  localparam logic [DW-1:0] D1 = 32'h0000_00B1;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [NB-1:0]              req_i;
  logic [NB-1:0]              gnt_o;
  logic [NB-1:0][DW-1:0]      data_i;
  logic                       req_o;
  logic                       gnt_i;
  logic [DW-1:0]              data_o;
  logic [CW-1:0]              cid_o;
  logic                       done_i;
  logic [CW-1:0]              done_cid_i;
  logic [NB-1:0][CNW-1:0]     outstd_o;
  logic                       err_o;
  logic                       busy_o;

  int n_checks = 0;
  int n_errors = 0;

  trans_credit_arbiter #(
    .NB_CTRLS        (NB),
    .DATA_WIDTH      (DW),
    .TRANS_CID_WIDTH (CW),
    .MAX_OUTSTD      (MO),
    .CNT_WIDTH       (CNW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .data_i     (data_i),
    .req_o      (req_o),
    .gnt_i      (gnt_i),
    .data_o     (data_o),
    .cid_o      (cid_o),
    .done_i     (done_i),
    .done_cid_i (done_cid_i),
    .outstd_o   (outstd_o),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  req;
    logic        gi;
    logic        done;
    logic        dcid;
    logic [1:0]  e_gnt;
    logic        e_req;
    logic        e_cid;
    logic [31:0] e_data;
    logic [2:0]  e_c0;
    logic [2:0]  e_c1;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic [1:0] req, logic gi, logic done, logic dcid,
                              logic [1:0] e_gnt, logic e_req, logic e_cid,
                              logic [31:0] e_data, logic [2:0] e_c0,
                              logic [2:0] e_c1, logic e_err, logic e_busy);
    vec_t v;
    v.req = req; v.gi = gi; v.done = done; v.dcid = dcid;
    v.e_gnt = e_gnt; v.e_req = e_req; v.e_cid = e_cid; v.e_data = e_data;
    v.e_c0 = e_c0; v.e_c1 = e_c1; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge and let combinational outputs settle.
  task automatic step(input logic [1:0] req, input logic gi, input logic done,
                      input logic dcid);
    @(negedge clk_i);
    req_i      = req;
    gnt_i      = gi;
    done_i     = done;
    done_cid_i = dcid;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 2'b00; gnt_i = 1'b0; done_i = 1'b0; done_cid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  int gcount;

  initial begin
    //               req  gi done cid | gnt  req cid data c0 c1 err busy
    vecs[0]  = mk(2'b11, 1, 0, 0, 2'b01, 0, 0, 32'h0, 0, 0, 0, 0);
    vecs[1]  = mk(2'b11, 1, 0, 0, 2'b10, 1, 0, D0,    1, 0, 0, 1);
    vecs[2]  = mk(2'b11, 1, 0, 0, 2'b01, 1, 1, D1,    1, 1, 0, 1);
    vecs[3]  = mk(2'b11, 1, 0, 0, 2'b10, 1, 0, D0,    2, 1, 0, 1);
    vecs[4]  = mk(2'b11, 1, 0, 0, 2'b01, 1, 1, D1,    2, 2, 0, 1);
    vecs[5]  = mk(2'b11, 1, 0, 0, 2'b10, 1, 0, D0,    3, 2, 0, 1);
    vecs[6]  = mk(2'b11, 1, 0, 0, 2'b01, 1, 1, D1,    3, 3, 0, 1);
    vecs[7]  = mk(2'b11, 1, 0, 0, 2'b10, 1, 0, D0,    4, 3, 0, 1);
    vecs[8]  = mk(2'b11, 1, 0, 0, 2'b00, 1, 1, D1,    4, 4, 0, 1);
    vecs[9]  = mk(2'b11, 1, 0, 0, 2'b00, 0, 1, D1,    4, 4, 0, 1);
    vecs[10] = mk(2'b11, 1, 1, 0, 2'b00, 0, 1, D1,    4, 4, 0, 1);
    vecs[11] = mk(2'b11, 1, 0, 0, 2'b01, 0, 1, D1,    3, 4, 0, 1);
    vecs[12] = mk(2'b11, 1, 0, 0, 2'b00, 1, 0, D0,    4, 4, 0, 1);

    data_i[0] = D0;
    data_i[1] = D1;
    do_reset();

    // Fairness, credit ceiling and credit return.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].req, vecs[i].gi, vecs[i].done, vecs[i].dcid);
      check($sformatf("v%0d gnt_o", i),  32'(gnt_o),       32'(vecs[i].e_gnt));
      check($sformatf("v%0d req_o", i),  32'(req_o),       32'(vecs[i].e_req));
      check($sformatf("v%0d cid_o", i),  32'(cid_o),       32'(vecs[i].e_cid));
      check($sformatf("v%0d data_o", i), data_o,           vecs[i].e_data);
      check($sformatf("v%0d cnt0", i),   32'(outstd_o[0]), 32'(vecs[i].e_c0));
      check($sformatf("v%0d cnt1", i),   32'(outstd_o[1]), 32'(vecs[i].e_c1));
      check($sformatf("v%0d err_o", i),  32'(err_o),       32'(vecs[i].e_err));
      check($sformatf("v%0d busy_o", i), 32'(busy_o),      32'(vecs[i].e_busy));
    end

    // Credit limit with a single requester.
    do_reset();
    gcount = 0;
    for (int i = 0; i < 6; i++) begin
      step(2'b01, 1'b1, 1'b0, 1'b0);
      if (gnt_o[0]) gcount++;
    end
    check("limit grant count", 32'(gcount), 32'd4);
    check("limit gnt_o idle", 32'(gnt_o), 32'd0);
    check("limit cnt0", 32'(outstd_o[0]), 32'd4);
    step(2'b01, 1'b1, 1'b1, 1'b0);
    check("limit done cycle gnt", 32'(gnt_o), 32'd0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    check("limit cnt after done", 32'(outstd_o[0]), 32'd3);
    check("limit regrant", 32'(gnt_o), 32'd1);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    check("limit cnt refilled", 32'(outstd_o[0]), 32'd4);
    check("limit gnt after refill", 32'(gnt_o), 32'd0);

    // Backpressure holds the output stage stable.
    do_reset();
    data_i[1] = 32'hA5A5_0001;
    step(2'b10, 1'b0, 1'b0, 1'b0);
    check("bp load gnt", 32'(gnt_o), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 1'b0, 1'b0, 1'b0);
      check($sformatf("bp%0d req_o", i),  32'(req_o), 32'd1);
      check($sformatf("bp%0d data_o", i), data_o,     32'hA5A5_0001);
      check($sformatf("bp%0d cid_o", i),  32'(cid_o), 32'd1);
      check($sformatf("bp%0d gnt_o", i),  32'(gnt_o), 32'd0);
    end
    step(2'b10, 1'b1, 1'b0, 1'b0);
    check("bp release gnt", 32'(gnt_o), 32'd2);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("bp second load cnt1", 32'(outstd_o[1]), 32'd2);
    data_i[1] = D1;

    // Simultaneous increment/decrement, then underflow.
    do_reset();
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b1, 1'b0);
    check("incdec pre cnt0", 32'(outstd_o[0]), 32'd2);
    check("incdec gnt", 32'(gnt_o), 32'd1);
    step(2'b00, 1'b1, 1'b1, 1'b1);
    check("incdec post cnt0", 32'(outstd_o[0]), 32'd2);
    check("incdec err", 32'(err_o), 32'd0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("uflow cnt1", 32'(outstd_o[1]), 32'd0);
    check("uflow err pulse", 32'(err_o), 32'd1);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("uflow err clear", 32'(err_o), 32'd0);

    // Reset in the middle of operation.
    do_reset();
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    check("mid req_o", 32'(req_o), 32'd1);
    check("mid cnt0", 32'(outstd_o[0]), 32'd3);
    check("mid cnt1", 32'(outstd_o[1]), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1; req_i = 2'b11; gnt_i = 1'b1;
    #1;
    check("rst cycle gnt", 32'(gnt_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("post rst req_o", 32'(req_o), 32'd0);
    check("post rst cnt0", 32'(outstd_o[0]), 32'd0);
    check("post rst cnt1", 32'(outstd_o[1]), 32'd0);
    check("post rst err", 32'(err_o), 32'd0);
    check("post rst busy", 32'(busy_o), 32'd0);
    check("post rst first gnt", 32'(gnt_o), 32'd1);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("post rst cid", 32'(cid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trans_credit_arbiter.md
Name: trans_credit_arbiter

Overview:
- Shares the single mchan transaction-queue input among NB_CTRLS command controllers.
- Uses round-robin arbitration with a per-controller credit limit on transactions that are in flight.
- Holds the granted command in a one-entry registered output stage that feeds the transaction queue through a req/gnt handshake.
- Returns credits when the back end signals completion, tagged with the controller ID (cid).

Parameters:
- NB_CTRLS, 2, number of requesting controllers (must be at least 2).
- DATA_WIDTH, 32, width of the packed command payload for one controller.
- TRANS_CID_WIDTH, 1, controller ID width; must equal $clog2(NB_CTRLS).
- MAX_OUTSTD, 4, maximum in-flight transactions per controller (must be at least 1).
- CNT_WIDTH, $clog2(MAX_OUTSTD+1), width of each credit counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NB_CTRLS  per-controller command request
- gnt_o  out  NB_CTRLS  per-controller grant; one-hot or zero
- data_i  in  NB_CTRLS x DATA_WIDTH  per-controller packed command
- req_o  out  1  output command valid
- gnt_i  in  1  transaction queue accepts the output command
- data_o  out  DATA_WIDTH  registered command payload
- cid_o  out  TRANS_CID_WIDTH  index of the controller that owns data_o
- done_i  in  1  completion pulse from the back end
- done_cid_i  in  TRANS_CID_WIDTH  controller ID of the completed transaction
- outstd_o  out  NB_CTRLS x CNT_WIDTH  per-controller in-flight count
- err_o  out  1  one-cycle pulse on a credit underflow attempt
- busy_o  out  1  high when any count is non-zero or req_o is high

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: req_o=0, data_o=0, cid_o=0, all counts=0, err_o=0, round-robin pointer=0.
- Reset mid-operation: reset wins over every other event in the same cycle. A pending output command is dropped, counters are cleared, and no gnt_o is issued in the reset cycle.
- Eligibility: controller k is eligible when req_i[k]=1 and cnt[k]<MAX_OUTSTD. Eligibility uses the registered count only; a done_i in the same cycle does not make a controller eligible that cycle.
- Slot free: free = !req_o || gnt_i.
- Grant: when free=1 and at least one controller is eligible, gnt_o is one-hot on the winner in the same cycle (combinational).
- Winner selection: the first eligible index at or after the pointer, searching modulo NB_CTRLS.
- When free=0, or no controller is eligible, gnt_o=0.
- On a grant, at the next edge:
  - data_o <= data_i[win];
  - cid_o <= win;
  - req_o <= 1;
  - pointer <= (win+1) mod NB_CTRLS.
- When free=1 and there is no grant: req_o <= 0 at the next edge. data_o and cid_o hold their values.
- Latency: one cycle from gnt_o to req_o.
- Back-to-back: a new command may be loaded in the cycle where gnt_i=1. This sustains one command per cycle.
- Output stability: while req_o=1 and gnt_i=0, data_o and cid_o hold stable.
- Counter update for controller k, where inc = gnt_o[k] and dec = done_i && done_cid_i==k:
  - inc and dec both set: count unchanged;
  - inc only: +1;
  - dec only: -1.
- Underflow: dec with cnt[k]=0 is ignored (count stays 0) and err_o pulses 1 on the next cycle.
- done_cid_i >= NB_CTRLS is ignored and pulses err_o.
- Overflow cannot occur because eligibility masks a controller at MAX_OUTSTD.
- Controllers hold req_i and data_i until gnt_o; the block does not latch requests.

Decomposition:
- Package mchan_arb_pkg holds the cid_t and cnt_t typedefs and a localparam RR_PTR_W = TRANS_CID_WIDTH.
- Sub-module trans_rr_picker is a combinational round-robin picker.
  - Inputs: eligible vector and pointer.
  - Outputs: one-hot grant, winner index, any-valid flag.
  - It is instantiated once.
- The output register, counters, pointer and error logic are written inline.

Test Plan:
- Fairness: NB_CTRLS=2, req_i=2'b11 held, gnt_i=1 always, done_i=0 -> gnt_o alternates 01,10,01,10; cid_o sequence 0,1,0,1 starting one cycle after reset release; counters stop at 4 each; after that, gnt_o=0 and req_o drops.
- Credit limit: req_i[0]=1 only, gnt_i=1, no done, MAX_OUTSTD=4 -> exactly 4 grants, outstd_o[0]=4, gnt_o[0]=0 thereafter; one done_i with cid 0 -> count 3, then one grant next cycle -> count back to 4.
- Backpressure: load a command with data_i[1]=0xA5A5_0001, hold gnt_i=0 for 5 cycles -> req_o=1, data_o=0xA5A5_0001, cid_o=1 stable for all 5 cycles and gnt_o=0 throughout; on gnt_i=1, a new grant is issued in that same cycle.
- Simultaneous inc/dec: cnt[0]=2, gnt_o[0]=1 and done_i with cid 0 in the same cycle -> outstd_o[0] stays 2; done_i on cnt=0 -> count stays 0 and err_o=1 for one cycle.
- Reset mid-operation: req_o=1 and counts {3,1}, assert rst_i for 1 cycle with gnt_i=1 -> next cycle req_o=0, counts {0,0}, err_o=0, busy_o=0; the first post-reset grant goes to controller 0 when both request.
